// File: rtl/tinyml_pkg.sv
// Shared definitions for the TinyML MAC sequencer and its front ends.
package tinyml_pkg;

  // Default datapath geometry.
  localparam int TINYML_DATA_W = 32;
  localparam int TINYML_LEN_W  = 8;

  // Custom-0 opcode space used by the PCPI front end when it issues commands.
  localparam logic [6:0] TINYML_OPCODE    = 7'b0001011;
  localparam logic [2:0] TINYML_F3_DOT    = 3'b000;  // start a dot-product command
  localparam logic [2:0] TINYML_F3_RESULT = 3'b001;  // collect the returned result
  localparam logic [2:0] TINYML_F3_STATUS = 3'b010;  // poll busy

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } seq_state_e;

  // ReLU decision: the value survives unless ReLU is enabled and its sign bit is set.
  // Kept width-agnostic so any DATA_W can use it by passing the MSB.
  function automatic logic relu_keep(input logic relu_en, input logic sign_bit);
    return !(relu_en && sign_bit);
  endfunction

endpackage

// File: rtl/tinyml_mac_pipe.sv
// Two-stage multiply/accumulate datapath: product register, then accumulator.
module tinyml_mac_pipe
  import tinyml_pkg::*;
#(
  parameter int DATA_W = TINYML_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              clear,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] acc_next
);

  logic [DATA_W-1:0] prod_q, prod_d;
  logic              prod_vld_q, prod_vld_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  // Stage 1 captures the truncated product; stage 2 folds a valid product into the sum.
  // Bubbles (in_valid low) leave the accumulator untouched.
  always_comb begin
    prod_d     = prod_q;
    prod_vld_d = in_valid;
    acc_d      = acc_q;
    if (in_valid) begin
      prod_d = in_a * in_b;
    end
    if (clear) begin
      acc_d = '0;
    end else if (prod_vld_q) begin
      acc_d = acc_q + prod_q;
    end
  end

  // Pipeline registers; reset discards any in-flight product and partial sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
    end
  end

  assign acc      = acc_q;
  assign acc_next = acc_d;

endmodule

// File: rtl/tinyml_mac_sequencer.sv
// Command-driven dot-product sequencer around the two-stage MAC pipeline.
module tinyml_mac_sequencer
  import tinyml_pkg::*;
#(
  parameter int DATA_W = TINYML_DATA_W,
  parameter int LEN_W  = TINYML_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_clear,
  input  logic              cmd_relu,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
);

  seq_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              relu_q, relu_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;

  logic              cmd_fire;
  logic              op_fire;
  logic              pipe_clear;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;

  function automatic logic [DATA_W-1:0] apply_relu(input logic en, input logic [DATA_W-1:0] x);
    return relu_keep(en, x[DATA_W-1]) ? x : '0;
  endfunction

  // Handshake outputs come from registered state only; cmd_ready is additionally
  // held low while reset is asserted.
  assign cmd_ready  = (state_q == ST_IDLE) && !reset;
  assign op_ready   = (state_q == ST_STREAM) && (cnt_q < len_q);
  assign res_valid  = (state_q == ST_RESULT);
  assign busy       = (state_q != ST_IDLE);
  assign res_data   = res_data_q;

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign op_fire    = op_valid && op_ready;
  assign pipe_clear = cmd_fire && cmd_clear;

  tinyml_mac_pipe #(
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (op_fire),
    .in_a     (op_a),
    .in_b     (op_b),
    .clear    (pipe_clear),
    .acc      (acc),
    .acc_next (acc_next)
  );

  // Next-state and datapath-control decode for the command FSM.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    relu_d     = relu_q;
    res_data_d = res_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          len_d  = cmd_len;
          relu_d = cmd_relu;
          cnt_d  = '0;
          if (cmd_len != '0) begin
            state_d = ST_STREAM;
          end else begin
            // Empty vector: the pipeline is already drained, so the result is
            // the (possibly cleared) accumulator right now.
            res_data_d = apply_relu(cmd_relu, cmd_clear ? '0 : acc);
            state_d    = ST_RESULT;
          end
        end
      end
      ST_STREAM: begin
        if (op_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The last product is being added this cycle; capture the sum it produces.
        res_data_d = apply_relu(relu_q, acc_next);
        state_d    = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and command-context registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      relu_q     <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      relu_q     <= relu_d;
      res_data_q <= res_data_d;
    end
  end

endmodule

// File: tb/tb_tinyml_mac_sequencer.sv
// Self-checking bench: directed vector table, reset corner case, randomized commands vs model.
module tb_tinyml_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_len = '0;
  logic        cmd_clear = 1'b0;
  logic        cmd_relu = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        busy;

  tinyml_mac_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_clear (cmd_clear),
    .cmd_relu  (cmd_relu),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] model_acc = '0;

  typedef struct {
    string             name;
    int                len;
    bit                clr;
    bit                relu;
    bit                gaps;
    int                stall;
    logic [3:0][31:0]  a;
    logic [3:0][31:0]  b;
    logic [31:0]       exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: dot product with modulo-2^32 arithmetic, ReLU on the returned value only.
  function automatic logic [31:0] model_cmd(input int len, input bit clr, input bit relu);
    if (clr) model_acc = '0;
    for (int i = 0; i < len; i++) model_acc = model_acc + qa[i] * qb[i];
    return (relu && model_acc[31]) ? 32'd0 : model_acc;
  endfunction

  task automatic add_vec(input string name, input int len, input bit clr, input bit relu,
                         input bit gaps, input int stall,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input logic [31:0] a2, input logic [31:0] b2,
                         input logic [31:0] exp);
    vec_t v;
    v.name = name; v.len = len; v.clr = clr; v.relu = relu; v.gaps = gaps; v.stall = stall;
    v.a = '0; v.b = '0;
    v.a[0] = a0; v.b[0] = b0;
    v.a[1] = a1; v.b[1] = b1;
    v.a[2] = a2; v.b[2] = b2;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  // Runs one command with operands from qa/qb; entered and left on a falling edge.
  task automatic run_cmd(input string tag, input int len, input bit clr, input bit relu,
                         input bit gaps, input int stall, input logic [31:0] exp);
    int sent = 0;
    int t_cmd;
    int t_last = 0;
    int guard = 0;
    int exp_cyc;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_len   = len[7:0];
    cmd_clear = clr;
    cmd_relu  = relu;
    t_cmd     = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_len   = 8'($urandom);
    cmd_clear = 1'($urandom);
    cmd_relu  = 1'($urandom);
    check({tag, ".busy_after_cmd"}, 32'(busy), 32'd1);
    guard = 0;
    while (!res_valid && guard < 2000) begin
      if (sent < len && (!gaps || $urandom_range(0, 2) != 0)) begin
        op_valid = 1'b1;
        op_a     = qa[sent];
        op_b     = qb[sent];
      end else begin
        op_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
      end
      if (op_valid && op_ready) begin
        sent++;
        t_last = cyc;
      end
      @(negedge clk);
      guard++;
    end
    op_valid = 1'b0;
    check({tag, ".res_valid"}, 32'(res_valid), 32'd1);
    check({tag, ".ops_taken"}, 32'(sent), 32'(len));
    exp_cyc = (len == 0) ? t_cmd + 1 : t_last + 2;
    check({tag, ".latency_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, ".res_data"}, res_data, exp);
    check({tag, ".op_ready_in_result"}, 32'(op_ready), 32'd0);
    // Hold the result; meanwhile offer a command and junk operands that must be ignored.
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1;
      op_valid  = 1'b1;
      op_a      = $urandom;
      op_b      = $urandom;
      check({tag, ".cmd_ready_in_result"}, 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check({tag, ".res_valid_stalled"}, 32'(res_valid), 32'd1);
      check({tag, ".res_data_stalled"}, res_data, exp);
    end
    cmd_valid = 1'b0;
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, ".busy_after_result"}, 32'(busy), 32'd0);
    check({tag, ".cmd_ready_after_result"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check({tag, ".no_queued_cmd"}, 32'(busy), 32'd0);
    $display("CMD %-10s len=%0d clr=%0d relu=%0d stall=%0d res=0x%08h exp=0x%08h",
             tag, len, clr, relu, stall, res_data, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, ".op_ready"}, 32'(op_ready), 32'd0);
    check({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    check({tag, ".res_data"}, res_data, 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [31:0] exp;
    int len;
    bit clr, relu, gaps;

    add_vec("basic",   3, 1, 0, 0, 0, 32'd2, 32'd3, 32'd4, 32'd5, 32'hFFFF_FFFF, 32'd6, 32'd20);
    add_vec("relu",    2, 1, 1, 0, 0, 32'hFFFF_FFFD, 32'd4, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0);
    add_vec("chain",   1, 0, 0, 0, 0, 32'd5, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFB);
    add_vec("seven",   1, 1, 0, 0, 0, 32'd7, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7);
    add_vec("zerolen", 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7);
    add_vec("wrap_bp", 2, 1, 0, 1, 5, 32'h0001_0000, 32'h0001_0000, 32'h7FFF_FFFF, 32'd2,
            32'd0, 32'd0, 32'hFFFF_FFFE);
    add_vec("relu_pos", 2, 1, 1, 1, 2, 32'd9, 32'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd80);

    // Reset values while reset is held.
    @(negedge clk);
    check_reset_outputs("reset_hold");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset.cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_reset.busy", 32'(busy), 32'd0);

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      qa.delete(); qb.delete();
      for (int k = 0; k < v.len; k++) begin
        qa.push_back(v.a[k]);
        qb.push_back(v.b[k]);
      end
      void'(model_cmd(v.len, v.clr, v.relu));
      run_cmd(v.name, v.len, v.clr, v.relu, v.gaps, v.stall, v.exp);
    end

    // Reset after two of four operands: nothing must be emitted, state must be clean.
    cmd_valid = 1'b1; cmd_len = 8'd4; cmd_clear = 1'b1; cmd_relu = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      op_valid = 1'b1;
      op_a = 32'(k + 11);
      op_b = 32'd3;
      @(negedge clk);
    end
    op_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_acc = '0;
    @(negedge clk);
    check("reset_mid.release_busy", 32'(busy), 32'd0);
    qa.delete(); qb.delete();
    qa.push_back(32'd3); qb.push_back(32'd3);
    void'(model_cmd(1, 1, 0));
    run_cmd("after_rst", 1, 1, 0, 0, 0, 32'd9);

    // Randomized commands against the reference model.
    for (int i = 0; i < 24; i++) begin
      len  = $urandom_range(0, 6);
      clr  = (i == 0) || ($urandom_range(0, 3) == 0);
      relu = 1'($urandom);
      gaps = 1'($urandom);
      qa.delete(); qb.delete();
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 1) == 0) begin
          qa.push_back(32'($signed($urandom_range(0, 40)) - 20));
          qb.push_back(32'($signed($urandom_range(0, 40)) - 20));
        end else begin
          qa.push_back($urandom);
          qb.push_back($urandom);
        end
      end
      exp = model_cmd(len, clr, relu);
      run_cmd($sformatf("rand%0d", i), len, clr, relu, gaps, $urandom_range(0, 3), exp);
    end

    // Maximum vector length.
    qa.delete(); qb.delete();
    for (int k = 0; k < 255; k++) begin
      qa.push_back($urandom);
      qb.push_back($urandom);
    end
    exp = model_cmd(255, 1, 0);
    run_cmd("maxlen", 255, 1, 0, 0, 1, exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinyml_mac_sequencer.md
# tinyml_mac_sequencer

Command-driven sequencer for the TinyML multiply-accumulate datapath. Accepts a dot-product command (vector length, clear, ReLU), pulls that many operand pairs from a valid/ready stream, and pushes each pair through a two-stage multiply/accumulate pipeline. It returns one 32-bit result per command on a valid/ready result port. It sits between the PCPI-facing front end (or a DMA operand feeder) and the MAC arithmetic, so a whole vector runs from one command instead of one custom instruction per element.

## Interface
- `DATA_W`, 32: operand, accumulator and result width
- `LEN_W`, 8: width of the command length field; max vector length 2^LEN_W-1
- `clk` in 1: single clock; all state on rising edge
- `reset` in 1: asynchronous, active-high reset
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: command accepted this cycle when `cmd_valid` is also high
- `cmd_len` in LEN_W: number of operand pairs
- `cmd_clear` in 1: 1 = accumulator starts from 0; 0 = continue from retained accumulator
- `cmd_relu` in 1: apply ReLU to the returned result
- `op_valid` in 1: operand pair offered
- `op_ready` out 1: operand pair consumed this cycle when `op_valid` is also high
- `op_a`, `op_b` in DATA_W: multiplicands
- `res_valid` out 1: result available
- `res_ready` in 1: result consumed
- `res_data` out DATA_W: result
- `busy` out 1: high in every state except IDLE

## Operation
- **States:** IDLE, STREAM, DRAIN, RESULT.
- **IDLE**
  - `cmd_ready`=1.
  - On command handshake: latch `cmd_len` and `cmd_relu`; zero the accumulator if `cmd_clear`=1; reset the element counter to 0.
  - Next state is STREAM if `cmd_len`≠0.
  - If `cmd_len`=0, go directly to RESULT with `res_data` = relu?(acc), using the cleared or retained accumulator.
- **STREAM**
  - `op_ready`=1 while counter < len.
  - Each op handshake registers the product and increments the counter.
  - Gaps in `op_valid` are allowed; the pipeline simply sees bubbles.
  - After the handshake that brings counter to len, go to DRAIN.
- **DRAIN**
  - `op_ready`=0.
  - The final product is accumulated.
  - `res_data` is registered from the final accumulator value, with ReLU applied if latched.
  - Next state is RESULT.
- **RESULT**
  - `res_valid`=1; `res_data` is held stable until `res_ready`.
  - On handshake, go to IDLE.
- **Arithmetic**
  - Product = low DATA_W bits of `op_a*op_b`.
  - Accumulation is modulo 2^DATA_W with no saturation; wrap-around is silent.
- **ReLU:** result = 0 when bit DATA_W-1 is set, else unchanged.
  - Affects `res_data` only. The accumulator keeps the raw sum for chained commands (`cmd_clear`=0).
- **Ignored inputs:** `cmd_valid` outside IDLE is ignored (`cmd_ready`=0), and the command is not queued. `op_valid` outside STREAM is ignored.
- **Reset:** may assert mid-operation. Any in-flight product and partial sum are discarded; no result is emitted.

## Timing
- **Reset values:** `cmd_ready`=0 during reset, 1 the first cycle after release (IDLE). `op_ready`=0, `res_valid`=0, `res_data`=0, `busy`=0. Accumulator=0, counter=0, state IDLE.
- **Ready/valid outputs:** `cmd_ready`, `op_ready` and `res_valid` are decoded from registered state only. There is no combinational path from valid inputs to ready outputs.
- **Pipeline:** product register (stage 1), then accumulator (stage 2). Throughput is one pair per cycle.
- **Latency, nonzero len:** last op handshake in cycle T → DRAIN in T+1 → `res_valid` first high in T+2.
- **Latency, len=0:** command handshake in cycle C → `res_valid` high in C+1.
- **Back-to-back commands:** a result handshake in cycle R returns to IDLE in R+1. The next command is accepted no earlier than R+1, so there is one dead cycle between commands.
- **`busy`:** rises the cycle after command acceptance and falls the cycle after the result handshake.

## Structure
- **Shared package `tinyml_pkg`:** state enum (IDLE/STREAM/DRAIN/RESULT), default `DATA_W` and `LEN_W` constants, ReLU helper function. The custom opcode/funct3 constants go here too, for the front end that issues commands.
- **Sub-module `tinyml_mac_pipe`:** the two-stage multiply/accumulate datapath with in_valid, clear, and acc output.
  - The sequencer owns the FSM, counter and handshakes.

## Test plan
- **Basic:** clear=1, len=3, pairs (2,3),(4,5),(−1,6) streamed every cycle → `res_data`=20, `res_valid` exactly 2 cycles after the third op handshake.
- **ReLU and chaining:** clear=1, relu=1, len=2, (−3,4),(1,2) → `res_data`=0. Then clear=0, relu=0, len=1, (5,1) → `res_data`=−5 (0xFFFFFFFB), proving the raw accumulator was retained.
- **Zero length:** len=0, clear=0 after a prior result of 7 → `res_data`=7 one cycle after the command handshake, and `op_ready` never asserts.
- **Backpressure:** random gaps in `op_valid` plus `res_ready` held low 5 cycles → result correct, `res_data` stable while stalled. A `cmd_valid` during RESULT sees `cmd_ready`=0.
- **Wrap:** clear=1, len=2, (0x10000,0x10000),(0x7FFFFFFF,2) → `res_data`=0xFFFFFFFE (modulo wrap, no saturation).
- **Reset mid-stream:** reset asserted after 2 of 4 ops → all outputs at reset values immediately. A fresh clear=1, len=1, (3,3) command then returns 9.
